// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the default bit
// period used by both the transmitter and the receiver.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS    = 8;
   localparam int unsigned UART_CLKS_PER_BIT = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for a single asynchronous input; resets to the idle-high
// level so a UART line does not see a false start bit coming out of reset.
module uart_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_sync <= '1;
      else       r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, valid/ready byte output
// with one-cycle framing-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_rx,
   output logic [UART_DATA_BITS-1:0] o_data,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic                      o_frame_err,
   output logic                      o_overrun
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = $clog2(UART_DATA_BITS);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

   logic w_rx_s;

   uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_rx),
      .o_q   (w_rx_s)
   );

   uart_state_t               r_state,  w_state_nxt;
   logic [CW-1:0]             r_cnt,    w_cnt_nxt;
   logic [IW-1:0]             r_idx,    w_idx_nxt;
   logic [UART_DATA_BITS-1:0] r_shreg,  w_shreg_nxt;
   logic [UART_DATA_BITS-1:0] r_data,   w_data_nxt;
   logic                      r_valid,  w_valid_nxt;
   logic                      r_ferr,   w_ferr_nxt;
   logic                      r_ovr,    w_ovr_nxt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shreg <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shreg <= w_shreg_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
         r_ovr   <= w_ovr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_shreg_nxt = r_shreg;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid && !i_ready;
      w_ferr_nxt  = 1'b0;
      w_ovr_nxt   = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (!w_rx_s) begin
               w_state_nxt = ST_START;
               w_cnt_nxt   = '0;
            end
         end
         ST_START: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt   = '0;
               w_shreg_nxt = {w_rx_s, r_shreg[UART_DATA_BITS-1:1]};
               w_idx_nxt   = r_idx + IW'(1);
               if (r_idx == IDX_LAST) w_state_nxt = ST_STOP;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_STOP: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt = '0;
               if (w_rx_s) begin
                  // Leaving at the stop-bit centre lets a back-to-back start bit be caught.
                  w_state_nxt = ST_IDLE;
                  if (!r_valid || i_ready) begin
                     w_data_nxt  = r_shreg;
                     w_valid_nxt = 1'b1;
                  end else begin
                     w_ovr_nxt = 1'b1;
                  end
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = ST_BREAK;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_BREAK: begin
            if (w_rx_s) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_frame_err = r_ferr;
   assign o_overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames, scored
// against a transaction-level model of expected bytes, error pulses and overruns.
module tb_uart_rx;

   localparam int unsigned CPB  = 16;
   localparam int unsigned SYNC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] o_data;
   logic       o_valid, o_frame_err, o_overrun;

   uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_rx        (rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (ready),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun)
   );

   always #5 clk = ~clk;

   int unsigned tests = 0, fails = 0;
   int unsigned cyc = 0;
   int unsigned last_rise = 0;
   int unsigned fe_seen = 0, ov_seen = 0, exp_fe = 0, exp_ov = 0;
   logic [7:0] exp_q[$];
   logic       rand_ready = 1'b0;
   logic       prev_hold = 1'b0, prev_valid = 1'b0;
   logic [7:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are judged on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold  = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (o_frame_err) fe_seen++;
         if (o_overrun)   ov_seen++;
         chk("err_exclusive", 32'(o_frame_err & o_overrun), 32'd0);
         if (prev_hold) begin
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_data", 32'(o_data), 32'(prev_data));
         end
         if (o_valid && !prev_valid) last_rise = cyc;
         if (o_valid && ready) begin
            if (exp_q.size() == 0) chk("unexpected_byte", 32'(o_data), 32'hFFFF_FFFF);
            else chk("byte", 32'(o_data), 32'(exp_q.pop_front()));
         end
         prev_hold  = o_valid && !ready;
         prev_data  = o_data;
         prev_valid = o_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (CPB) tick();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic expect_byte);
      if (!stop_bit) exp_fe++;
      else if (expect_byte) exp_q.push_back(b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_bit);
   endtask

   task automatic idle(input int unsigned n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   task automatic end_phase(input string name);
      for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick();
      repeat (4) tick();
      chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_frame_err_count"}, fe_seen, exp_fe);
      chk({name, "_overrun_count"}, ov_seen, exp_ov);
   endtask

   initial begin
      int unsigned c0;
      int unsigned d;
      logic [7:0]  rb;

      repeat (3) tick();
      chk("reset_data", 32'(o_data), 32'd0);
      chk("reset_valid", 32'(o_valid), 32'd0);
      chk("reset_ferr", 32'(o_frame_err), 32'd0);
      chk("reset_ovr", 32'(o_overrun), 32'd0);
      rst = 1'b0;
      idle(20);

      // Single byte, latency against the rx falling edge.
      c0 = cyc;
      send_frame(8'hCA, 1'b1, 1'b1);
      end_phase("single");
      d = last_rise - c0;
      chk("latency_in_window", 32'(d >= 152 && d <= 156), 32'd1);
      chk("single_data_literal", 32'(o_data), 32'hCA);

      // Back-to-back frames with no idle gap.
      send_frame(8'hCA, 1'b1, 1'b1);
      send_frame(8'hB2, 1'b1, 1'b1);
      end_phase("b2b");
      chk("b2b_last_data", 32'(o_data), 32'hB2);

      // Consumer stalled: second byte dropped with one overrun pulse.
      idle(10);
      ready = 1'b0;
      send_frame(8'hCA, 1'b1, 1'b1);
      send_frame(8'hB2, 1'b1, 1'b0);
      exp_ov++;
      idle(20);
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_data", 32'(o_data), 32'hCA);
      chk("stall_overrun_once", ov_seen, 32'd1);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      tick();
      chk("stall_release_valid", 32'(o_valid), 32'd0);
      ready = 1'b1;
      end_phase("stall");

      // Short glitch is rejected, then a real frame still decodes.
      rx = 1'b0;
      repeat (5) tick();
      idle(8 + SYNC);
      chk("glitch_no_valid", 32'(o_valid), 32'd0);
      chk("glitch_no_ferr", fe_seen, exp_fe);
      send_frame(8'hB2, 1'b1, 1'b1);
      end_phase("glitch");

      // Bad stop bit followed by a long break.
      send_frame(8'h55, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (100) tick();
      idle(CPB);
      chk("break_one_ferr", fe_seen, 32'd1);
      send_frame(8'hB2, 1'b1, 1'b1);
      end_phase("break");

      // Reset in the middle of bit 4 of 0xCA abandons the frame.
      rx = 1'b0;
      repeat (CPB) tick();
      rb = 8'hCA;
      for (int i = 0; i < 4; i++) send_bit(rb[i]);
      rx = rb[4];
      repeat (CPB / 2) tick();
      rst = 1'b1;
      rx  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_mid_data", 32'(o_data), 32'd0);
         chk("rst_mid_valid", 32'(o_valid), 32'd0);
         chk("rst_mid_errs", 32'(o_frame_err | o_overrun), 32'd0);
      end
      rst = 1'b0;
      idle(2 * CPB);
      send_frame(8'hB2, 1'b1, 1'b1);
      end_phase("rst_mid");
      chk("rst_mid_final_data", 32'(o_data), 32'hB2);

      // Randomized mix of good frames, bad stop bits and glitches with a random consumer.
      rand_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         int unsigned kind;
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            rx = 1'b0;
            repeat ($urandom_range(1, 5)) tick();
            idle(10);
         end else if (kind == 1) begin
            send_frame(8'($urandom), 1'b0, 1'b0);
            rx = 1'b0;
            repeat ($urandom_range(0, 40)) tick();
            idle(CPB);
         end else begin
            send_frame(8'($urandom), 1'b1, 1'b1);
            idle($urandom_range(0, 20));
         end
      end
      rand_ready = 1'b0;
      ready = 1'b1;
      end_phase("random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Sits directly downstream of the team's UART transmitter and consumes its serial line (e.g. the sensor tag bytes 0xCA, 0xB2).
- Synchronises the asynchronous rx line, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit. Checks the stop bit.
- Presents each received byte on a valid/ready interface to the bot's command/telemetry logic.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit. Legal range 4..65535, must match the transmitter's bit period.
- SYNC_STAGES, 2, flops in the rx input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- data  out  8  received byte, stable while valid=1.
- valid  out  1  byte available.
- ready  in  1  consumer accepts data when valid&ready at a clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while previous byte still unaccepted.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - All synchroniser flops = 1; state = IDLE; bit counter and bit index = 0; shift register = 0.
  - data = 0x00; valid = 0; frame_err = 0; overrun = 0.
  - Reset mid-frame abandons the frame; no valid or error pulse results from it.
- Input path: rx passes through SYNC_STAGES flops -> rx_s. All decisions use rx_s only. Latency from rx to rx_s is SYNC_STAGES cycles.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s==0 -> START, cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - Sample 0 -> DATA, cnt=0, idx=0.
  - Sample 1 -> IDLE. Treated as a glitch: no flags raised.
- DATA:
  - cnt increments; at cnt==CLKS_PER_BIT-1, sample rx_s and reset cnt=0.
  - Sampled bit shifts into shreg[7] while shreg shifts right, so the first bit lands in data[0].
  - idx increments per sample; after the sample with idx==7 -> STOP.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: load the byte (rules below) -> IDLE. Returning at the stop-bit centre allows a back-to-back next start bit.
  - Sample 0: frame_err=1 for exactly one cycle, byte discarded, data/valid unchanged -> BREAK.
- BREAK:
  - Stay until rx_s==1, then -> IDLE. A line held low never produces further bytes or errors.
- Byte load at the stop sample edge, registered:
  - valid==0, or valid&ready in the same cycle: data<=shreg, valid<=1 on the next edge.
  - valid==1 and ready==0: data retained (old byte kept, new byte dropped), overrun=1 for one cycle, valid stays 1.
- Handshake:
  - valid falls on the edge after valid&ready, unless a new byte loads in that same cycle, in which case valid stays 1 with the new data.
  - data must not change while valid==1 and ready==0.
- Latency: valid rises 1 cycle after the stop-sample edge, i.e. SYNC_STAGES + 9.5*CLKS_PER_BIT (±1) cycles after the rx falling edge.
- frame_err and overrun never assert in the same cycle. Neither is sticky.
- Counter width: $clog2(CLKS_PER_BIT). No wrap occurs, since cnt is cleared at its terminal value.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK}.
  - UART_DATA_BITS=8.
  - Default CLKS_PER_BIT constant, shared with the transmitter so both ends agree on the bit period.
- One sub-module: uart_sync. SYNC_STAGES-deep synchroniser with async active-high reset to 1. Reusable for other async inputs such as sensor lines.

Test Plan:
- CLKS_PER_BIT=16, ready=1, drive frame for 0xCA -> single valid pulse, data=0xCA, frame_err=0, overrun=0. valid rises within 154±2 cycles of the start edge.
- 0xCA then 0xB2 back-to-back (no idle gap), ready=1 -> two valid pulses, data 0xCA then 0xB2, no errors.
- Hold ready=0, send 0xCA then 0xB2 -> valid stays 1, data stays 0xCA, overrun pulses once at the 0xB2 stop sample. Then ready=1 for one cycle -> valid=0.
- rx low for 5 cycles, then high -> no valid, no frame_err; FSM back in IDLE before cycle 8+SYNC_STAGES.
- Send 0x55 with stop bit 0, then hold rx low 100 cycles, then release -> exactly one frame_err pulse, no valid. Next 0xB2 frame is received correctly.
- Assert rst at bit 4 of 0xCA for 3 cycles, then send 0xB2 -> outputs zero during reset, no valid from the aborted frame, data=0xB2 received.
